// File: rtl/sprite_position_tracker.sv
// sprite_position_tracker: applies direction/move pulses to the sprite X/Y
// position, clamping (default) or wrapping at the visible-area edges, and
// hands each new position to the attribute writer over a req/ack handshake.
// A one-deep pending slot absorbs moves that arrive while an update is busy.
// Optional feature macro: SPRITE_WRAP_EN (defined = wrap at edges, undefined = clamp).
module sprite_position_tracker #(
  parameter int X_MAX  = 639,
  parameter int Y_MAX  = 479,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240,
  parameter int STEP   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] direction,
  input  logic       move,
  input  logic       wr_ack,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       wr_req,
  output logic       done,
  output logic [3:0] at_edge,
  output logic [7:0] drop_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [2:0]  DIR_LEFT  = 3'b001;
  localparam logic [2:0]  DIR_RIGHT = 3'b010;
  localparam logic [2:0]  DIR_UP    = 3'b011;
  localparam logic [2:0]  DIR_DOWN  = 3'b100;
  localparam logic [10:0] STEP11    = 11'(STEP);
  localparam logic [10:0] XLIM      = 11'(X_MAX);
  localparam logic [10:0] YLIM      = 11'(Y_MAX);

  state_t      state_q, state_d;
  logic [9:0]  pos_x_q, pos_x_d;
  logic [9:0]  pos_y_q, pos_y_d;
  logic [2:0]  dir_q, dir_d;
  logic        pend_vld_q, pend_vld_d;
  logic [2:0]  pend_dir_q, pend_dir_d;
  logic        done_q, done_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic        move_ok;

  // One STEP along an axis in 11-bit arithmetic; edge handling depends on build.
  function automatic logic [9:0] step_coord(input logic [9:0] c, input logic [10:0] lim,
                                            input logic inc);
    logic [10:0] c11;
    logic [10:0] r;
    c11 = {1'b0, c};
    r   = c11;
    if (inc) begin
      if (c11 + STEP11 > lim) begin
`ifdef SPRITE_WRAP_EN
        r = c11 + STEP11 - (lim + 11'd1);
`else
        r = lim;
`endif
      end else begin
        r = c11 + STEP11;
      end
    end else begin
      if (c11 < STEP11) begin
`ifdef SPRITE_WRAP_EN
        r = c11 + lim + 11'd1 - STEP11;
`else
        r = 11'd0;
`endif
      end else begin
        r = c11 - STEP11;
      end
    end
    return 10'(r);
  endfunction

  assign move_ok = move && (direction >= DIR_LEFT) && (direction <= DIR_DOWN);

  // Next-state, coordinate update and pending-slot bookkeeping.
  always_comb begin
    state_d    = state_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    dir_d      = dir_q;
    pend_vld_d = pend_vld_q;
    pend_dir_d = pend_dir_q;
    done_d     = 1'b0;
    drop_cnt_d = drop_cnt_q;

    case (state_q)
      IDLE: begin
        if (pend_vld_q) begin
          // Stored move wins; a simultaneous new move refills the slot.
          dir_d   = pend_dir_q;
          state_d = CALC;
          if (move_ok) begin
            pend_dir_d = direction;
          end else begin
            pend_vld_d = 1'b0;
          end
        end else if (move_ok) begin
          dir_d   = direction;
          state_d = CALC;
        end
      end
      CALC: begin
        case (dir_q)
          DIR_LEFT:  pos_x_d = step_coord(pos_x_q, XLIM, 1'b0);
          DIR_RIGHT: pos_x_d = step_coord(pos_x_q, XLIM, 1'b1);
          DIR_UP:    pos_y_d = step_coord(pos_y_q, YLIM, 1'b0);
          DIR_DOWN:  pos_y_d = step_coord(pos_y_q, YLIM, 1'b1);
          default:   ;
        endcase
        state_d = WRITE;
      end
      WRITE: begin
        if (wr_ack) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Moves arriving while busy land in the slot; latest wins, overwrites counted.
    if ((state_q != IDLE) && move_ok) begin
      pend_dir_d = direction;
      if (pend_vld_q) begin
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end else begin
        pend_vld_d = 1'b1;
      end
    end
  end

  // Control and position registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pos_x_q    <= 10'(X_INIT);
      pos_y_q    <= 10'(Y_INIT);
      pend_vld_q <= 1'b0;
      done_q     <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      pend_vld_q <= pend_vld_d;
      done_q     <= done_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Direction payloads are only read when qualified by state/valid, so no reset.
  always_ff @(posedge clk) begin
    dir_q      <= dir_d;
    pend_dir_q <= pend_dir_d;
  end

  assign pos_x    = pos_x_q;
  assign pos_y    = pos_y_q;
  assign wr_req   = (state_q == WRITE);
  assign done     = done_q;
  assign drop_cnt = drop_cnt_q;
  assign at_edge  = {(pos_y_q == 10'(Y_MAX)), (pos_y_q == 10'd0),
                     (pos_x_q == 10'(X_MAX)), (pos_x_q == 10'd0)};

endmodule

// File: tb/tb_sprite_position_tracker.sv
// Testbench for sprite_position_tracker: directed steps plus randomized
// transactions checked against a transaction-level position model.
module tb_sprite_position_tracker;

  localparam int X_MAX  = 639;
  localparam int Y_MAX  = 479;
  localparam int X_INIT = 320;
  localparam int Y_INIT = 240;
  localparam int STEP   = 4;

  logic       clk;
  logic       reset;
  logic [2:0] direction;
  logic       move;
  logic       wr_ack;
  logic [9:0] pos_x, pos_y;
  logic       wr_req, done;
  logic [3:0] at_edge;
  logic [7:0] drop_cnt;

  logic [2:0] e_dir;
  logic       e_move, e_ack;
  logic [9:0] e_pos_x, e_pos_y;
  logic       e_wr_req, e_done;
  logic [3:0] e_at_edge;
  logic [7:0] e_drop;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  int         mx, my, mdrop;
  bit         mslot_vld;
  logic [2:0] mslot_dir;
  logic [2:0] ex_q[$];

  sprite_position_tracker #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .X_INIT(X_INIT),
                            .Y_INIT(Y_INIT), .STEP(STEP)) dut (
    .clk(clk), .reset(reset), .direction(direction), .move(move), .wr_ack(wr_ack),
    .pos_x(pos_x), .pos_y(pos_y), .wr_req(wr_req), .done(done),
    .at_edge(at_edge), .drop_cnt(drop_cnt)
  );

  sprite_position_tracker #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .X_INIT(2),
                            .Y_INIT(478), .STEP(STEP)) dut_e (
    .clk(clk), .reset(reset), .direction(e_dir), .move(e_move), .wr_ack(e_ack),
    .pos_x(e_pos_x), .pos_y(e_pos_y), .wr_req(e_wr_req), .done(e_done),
    .at_edge(e_at_edge), .drop_cnt(e_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Move the model sprite one step; coordinates computed with plain signed ints.
  task automatic mapply(input logic [2:0] d);
    int nx, ny;
    nx = mx;
    ny = my;
    case (d)
      3'd1: nx = mx - STEP;
      3'd2: nx = mx + STEP;
      3'd3: ny = my - STEP;
      3'd4: ny = my + STEP;
      default: ;
    endcase
`ifdef SPRITE_WRAP_EN
    if (nx < 0) nx = nx + X_MAX + 1;
    if (nx > X_MAX) nx = nx - (X_MAX + 1);
    if (ny < 0) ny = ny + Y_MAX + 1;
    if (ny > Y_MAX) ny = ny - (Y_MAX + 1);
`else
    if (nx < 0) nx = 0;
    if (nx > X_MAX) nx = X_MAX;
    if (ny < 0) ny = 0;
    if (ny > Y_MAX) ny = Y_MAX;
`endif
    mx = nx;
    my = ny;
  endtask

  function automatic logic [31:0] exp_edge();
    logic [3:0] e;
    e = {(my == Y_MAX), (my == 0), (mx == X_MAX), (mx == 0)};
    return 32'(e);
  endfunction

  function automatic bit is_valid(input logic [2:0] d);
    return (d >= 3'd1) && (d <= 3'd4);
  endfunction

  task automatic check_pos(input string tag);
    chk({tag, "_x"}, 32'(pos_x), 32'(mx));
    chk({tag, "_y"}, 32'(pos_y), 32'(my));
    chk({tag, "_edge"}, 32'(at_edge), exp_edge());
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (wr_req !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req_seen"}, 32'(wr_req), 32'd1);
  endtask

  // One move plus any queued extra moves during the busy window, then ack.
  task automatic txn(input string tag, input logic [2:0] d0, input int ack_dly);
    move = 1'b1;
    direction = d0;
    @(negedge clk);
    if (!is_valid(d0)) begin
      move = 1'b0;
      wr_ack = 1'b1;
      repeat (3) begin
        @(negedge clk);
        chk({tag, "_inv_req"}, 32'(wr_req), 32'd0);
        chk({tag, "_inv_done"}, 32'(done), 32'd0);
      end
      wr_ack = 1'b0;
      check_pos({tag, "_inv"});
      chk({tag, "_inv_drop"}, 32'(drop_cnt), 32'(mdrop));
      ex_q.delete();
      return;
    end
    mapply(d0);
    foreach (ex_q[i]) begin
      move = 1'b1;
      direction = ex_q[i];
      if (is_valid(ex_q[i])) begin
        if (mslot_vld && mdrop < 255) mdrop++;
        mslot_vld = 1'b1;
        mslot_dir = ex_q[i];
      end
      @(negedge clk);
    end
    move = 1'b0;
    ex_q.delete();
    wait_req(tag);
    check_pos(tag);
    chk({tag, "_drop"}, 32'(drop_cnt), 32'(mdrop));
    repeat (ack_dly) begin
      @(negedge clk);
      chk({tag, "_hold_req"}, 32'(wr_req), 32'd1);
      chk({tag, "_hold_x"}, 32'(pos_x), 32'(mx));
      chk({tag, "_hold_y"}, 32'(pos_y), 32'(my));
    end
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_req_drop"}, 32'(wr_req), 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    if (mslot_vld) begin
      mslot_vld = 1'b0;
      mapply(mslot_dir);
      wait_req({tag, "_slot"});
      check_pos({tag, "_slot"});
      wr_ack = 1'b1;
      @(negedge clk);
      wr_ack = 1'b0;
      chk({tag, "_slot_done"}, 32'(done), 32'd1);
      @(negedge clk);
    end
  endtask

  initial begin
    int d_before;
    reset = 1'b1;
    move = 1'b0; direction = 3'd0; wr_ack = 1'b0;
    e_move = 1'b0; e_dir = 3'd0; e_ack = 1'b0;
    mx = X_INIT; my = Y_INIT; mdrop = 0; mslot_vld = 1'b0; mslot_dir = 3'd0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_x", 32'(pos_x), 32'd320);
    chk("rst_y", 32'(pos_y), 32'd240);
    chk("rst_req", 32'(wr_req), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_edge", 32'(at_edge), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Right move, ack tied high: exact latency.
    move = 1'b1; direction = 3'd2; wr_ack = 1'b1;
    @(negedge clk);
    move = 1'b0;
    chk("r1_calc_req", 32'(wr_req), 32'd0);
    chk("r1_calc_x", 32'(pos_x), 32'd320);
    @(negedge clk);
    chk("r1_write_req", 32'(wr_req), 32'd1);
    chk("r1_write_x", 32'(pos_x), 32'd324);
    chk("r1_write_y", 32'(pos_y), 32'd240);
    chk("r1_write_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("r1_req_low", 32'(wr_req), 32'd0);
    chk("r1_done", 32'(done), 32'd1);
    wr_ack = 1'b0;
    @(negedge clk);
    chk("r1_done_once", 32'(done), 32'd0);
    mx = 324;

    // Edge instance: left from x=2, then down from y=478.
    e_ack = 1'b1; e_move = 1'b1; e_dir = 3'd1;
    @(negedge clk);
    e_move = 1'b0;
    repeat (3) @(negedge clk);
`ifdef SPRITE_WRAP_EN
    chk("edge_left_x", 32'(e_pos_x), 32'd638);
    chk("edge_left_flag", 32'(e_at_edge[0]), 32'd0);
`else
    chk("edge_left_x", 32'(e_pos_x), 32'd0);
    chk("edge_left_flag", 32'(e_at_edge[0]), 32'd1);
`endif
    e_move = 1'b1; e_dir = 3'd4;
    @(negedge clk);
    e_move = 1'b0;
    repeat (3) @(negedge clk);
`ifdef SPRITE_WRAP_EN
    chk("edge_down_y", 32'(e_pos_y), 32'd2);
    chk("edge_down_flag", 32'(e_at_edge[3]), 32'd0);
`else
    chk("edge_down_y", 32'(e_pos_y), 32'd479);
    chk("edge_down_flag", 32'(e_at_edge[3]), 32'd1);
`endif
    chk("edge_req_idle", 32'(e_wr_req), 32'd0);
    chk("edge_drop", 32'(e_drop), 32'd0);
    e_ack = 1'b0;

    // Ack held low 10 cycles, up then left arrive: up is lost, left applied.
    d_before = mdrop;
    ex_q.push_back(3'd3);
    ex_q.push_back(3'd1);
    txn("hold", 3'd2, 10);
    chk("hold_drop_inc", 32'(drop_cnt), 32'(d_before + 1));
    chk("hold_left_applied", 32'(pos_x), 32'd324);

    // Invalid codes with move: nothing happens.
    txn("dir000", 3'd0, 0);
    txn("dir110", 3'd6, 0);

    // Randomized transactions.
    for (int i = 0; i < 40; i++) begin
      int nex;
      nex = $urandom_range(0, 3);
      for (int k = 0; k < nex; k++) ex_q.push_back(3'($urandom_range(0, 7)));
      txn("rnd", 3'($urandom_range(0, 7)), $urandom_range(0, 4));
    end

    // Walk into the left and top edges.
    for (int i = 0; i < 85; i++) txn("walk_l", 3'd1, 0);
    for (int i = 0; i < 65; i++) txn("walk_u", 3'd3, 0);
    check_pos("walk_end");

    // Drop counter saturation.
    for (int i = 0; i < 260; i++) ex_q.push_back(3'd2);
    txn("sat", 3'd4, 1);
    chk("sat_drop", 32'(drop_cnt), 32'd255);

    // Reset during WRITE with a pending move queued.
    move = 1'b1; direction = 3'd2;
    @(negedge clk);
    direction = 3'd3;
    @(negedge clk);
    move = 1'b0;
    chk("arst_pre_req", 32'(wr_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_req_fall", 32'(wr_req), 32'd0);
    chk("arst_x", 32'(pos_x), 32'd320);
    chk("arst_y", 32'(pos_y), 32'd240);
    chk("arst_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    chk("arst_no_done", 32'(done), 32'd0);
    reset = 1'b1;
    mx = X_INIT; my = Y_INIT; mdrop = 0; mslot_vld = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("arst_slot_empty_req", 32'(wr_req), 32'd0);
      chk("arst_slot_empty_done", 32'(done), 32'd0);
    end
    check_pos("arst_after");
    txn("post_rst", 3'd4, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
